// File: rtl/dcache_pkg.sv
// dcache_pkg: controller state type and geometry helpers shared by the
// set-associative data cache and its per-set LRU tracker.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} dcache_state_e;

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int age_width(input int ways);
        return $clog2(ways);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets);
        return addr_w - 2 - $clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// dcache_lru: age-based LRU state for one set; ages stay a permutation of
// 0..WAYS-1 and the way holding age 0 is the replacement victim.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int WAYS = 4,
    localparam int AGE_W = age_width(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             touch,
    input  logic [AGE_W-1:0] touch_way,
    output logic [AGE_W-1:0] victim_way
);

    logic [AGE_W-1:0] age_q [WAYS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < WAYS; w++) age_q[w] <= AGE_W'(w);
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++)
                if (AGE_W'(w) == touch_way) age_q[w] <= AGE_W'(WAYS - 1);
                else if (age_q[w] > age_q[touch_way]) age_q[w] <= age_q[w] - AGE_W'(1);
        end
    end

    always_comb begin
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) if (age_q[w] == '0) victim_way = AGE_W'(w);
    end

endmodule

// File: rtl/assoc_dcache.sv
// assoc_dcache: N-way set-associative write-through, no-write-allocate data
// cache with one word per line, byte-enable stores, LRU and flush.
module assoc_dcache
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SETS   = 16,
    parameter int WAYS   = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    input  logic [DATA_W/8-1:0] cpu_be_i,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                cpu_ready_o,
    input  logic                flush_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int IDX_W = idx_width(SETS);
    localparam int AGE_W = age_width(WAYS);
    localparam int TAG_W = tag_width(ADDR_W, SETS);
    localparam int BE_W  = DATA_W / 8;

    dcache_state_e     state_q, state_d;
    logic              flush_pend_q;
    logic [DATA_W-1:0] rdata_q;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];
    logic [AGE_W-1:0]  lru_victim [SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WAYS-1:0]   hit_vec;
    logic              hit, flush_now, load_hit, ack_refill, ack_write, touch;
    logic [AGE_W-1:0]  hit_way, fill_way, touch_way;
    logic [DATA_W-1:0] hit_data, merged;
    logic              unused_ok;

    assign idx       = cpu_addr_i[2 +: IDX_W];
    assign tag       = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign unused_ok = ^cpu_addr_i[1:0];

    // Descending scan so the lowest-index invalid way wins as fill target.
    always_comb begin
        hit_vec  = '0;
        hit_way  = '0;
        hit_data = '0;
        fill_way = lru_victim[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid_q[idx][w] && tag_q[idx][w] == tag;
            if (hit_vec[w]) begin
                hit_way  = AGE_W'(w);
                hit_data = data_q[idx][w];
            end
            if (!valid_q[idx][w]) fill_way = AGE_W'(w);
        end
        merged = hit_data;
        for (int b = 0; b < BE_W; b++)
            merged[8*b +: 8] = cpu_be_i[b] ? cpu_wdata_i[8*b +: 8] : hit_data[8*b +: 8];
    end

    assign hit        = |hit_vec;
    assign flush_now  = state_q == IDLE && (flush_i || flush_pend_q);
    assign load_hit   = state_q == IDLE && !flush_now && cpu_req_i && !cpu_we_i && hit;
    assign ack_refill = state_q == REFILL && mem_ack_i;
    assign ack_write  = state_q == WRITE && mem_ack_i;
    assign touch      = load_hit || ack_refill || (ack_write && hit);
    assign touch_way  = ack_refill ? fill_way : hit_way;

    assign mem_req_o   = state_q == REFILL || state_q == WRITE;
    assign mem_we_o    = state_q == WRITE;
    assign mem_addr_o  = mem_req_o ? {cpu_addr_i[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata_o = mem_we_o ? cpu_wdata_i : '0;
    assign mem_be_o    = state_q == REFILL ? '1 : mem_we_o ? cpu_be_i : '0;
    assign cpu_ready_o = load_hit || state_q == RESP || ack_write;
    assign cpu_rdata_o = state_q == RESP ? rdata_q : load_hit ? hit_data : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!flush_now && cpu_req_i) state_d = cpu_we_i ? WRITE : hit ? IDLE : REFILL;
            REFILL:  if (mem_ack_i) state_d = RESP;
            WRITE:   if (mem_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            rdata_q      <= '0;
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= state_q == IDLE ? 1'b0 : flush_pend_q || flush_i;
            if (flush_now) for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            if (ack_refill) begin
                valid_q[idx][fill_way] <= 1'b1;
                rdata_q                <= mem_rdata_i;
            end
        end
    end

    // Tag/data need no reset: valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (ack_refill) begin
            tag_q[idx][fill_way]  <= tag;
            data_q[idx][fill_way] <= mem_rdata_i;
        end else if (ack_write && hit) begin
            data_q[idx][hit_way] <= merged;
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_lru
        dcache_lru #(.WAYS(WAYS)) u_lru (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .touch      (touch && idx == IDX_W'(s)),
            .touch_way  (touch_way),
            .victim_way (lru_victim[s])
        );
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) mem_req_o |-> cpu_req_i);

endmodule

// File: tb/tb_assoc_dcache.sv
// tb_assoc_dcache: randomized and directed scoreboard bench for assoc_dcache
// against a recency-list cache model and a latency-programmable memory.
module tb_assoc_dcache;

    localparam int SETS = 16;
    localparam int WAYS = 4;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0, flush_i = 1'b0;
    logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0, cpu_rdata_o;
    logic [3:0]  cpu_be_i = '0, mem_be_o;
    logic        cpu_ready_o, mem_req_o, mem_we_o, mem_ack_i = 1'b0;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;

    assoc_dcache dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_be_i(cpu_be_i),
        .cpu_rdata_o(cpu_rdata_o), .cpu_ready_o(cpu_ready_o), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_mem;
        int          exp_lat;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0, errors = 0;
    int          lat = 0, nwr = 0, wcnt = 0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_rdata = '0;
    logic [31:0] mem_arr [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    int unsigned rec_q [$];

    function automatic logic [31:0] init_word(input int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input int unsigned w);
        return mem_arr.exists(w) ? mem_arr[w] : init_word(w);
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    // Cache contents as a recency list of line numbers; oldest entry of a set is evicted.
    function automatic bit model_access(input bit we, input logic [31:0] addr);
        int unsigned line = addr >> 2;
        int pos = -1, first = -1, cnt = 0;
        for (int i = 0; i < rec_q.size(); i++) begin
            if (rec_q[i] == line) pos = i;
            if (rec_q[i] % SETS == line % SETS) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        if (pos >= 0) begin
            rec_q.delete(pos);
            rec_q.push_back(line);
            return 1'b1;
        end
        if (!we) begin
            if (cnt == WAYS) rec_q.delete(first);
            rec_q.push_back(line);
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_tb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Memory: acks `lat` cycles after it first sees a request.
    always @(posedge clk_i) begin
        int unsigned w;
        logic [31:0] v;
        #1;
        mem_ack_i = 1'b0;
        if (mem_req_o) begin
            if (wcnt >= lat) begin
                mem_ack_i = 1'b1;
                wcnt = 0;
                w = mem_addr_o >> 2;
                last_be = mem_be_o;
                if (mem_we_o) begin
                    v = mem_rd(w);
                    for (int b = 0; b < 4; b++) if (mem_be_o[b]) v[8*b +: 8] = mem_wdata_o[8*b +: 8];
                    mem_arr[w] = v;
                    nwr++;
                end else begin
                    mem_rdata_i = mem_rd(w);
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    int cyc = 0;
    bit seen = 1'b0;
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            cyc = 0;
            seen = 1'b0;
        end else if (sb.size() > 0) begin
            if (mem_req_o) seen = 1'b1;
            if (cpu_ready_o) begin
                e = sb.pop_front();
                if (!e.we) chk($sformatf("rdata@%h", e.addr), cpu_rdata_o, e.data);
                chk($sformatf("mem_used@%h we=%0b", e.addr, e.we), 32'(seen), 32'(e.exp_mem));
                chk($sformatf("latency@%h we=%0b", e.addr, e.we), 32'(cyc), 32'(e.exp_lat));
                cyc = 0;
                seen = 1'b0;
            end else begin
                cyc++;
            end
        end
    end

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int force_hit, output int cycles);
        exp_t e;
        bit h;
        int unsigned w = addr >> 2;
        logic [31:0] v;
        h = model_access(we, addr);
        if (force_hit >= 0) h = force_hit != 0;
        if (we) begin
            v = ref_rd(w);
            for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[w] = v;
        end
        e.we = we;
        e.addr = addr;
        e.data = ref_rd(w);
        e.exp_mem = we || !h;
        e.exp_lat = we ? lat + 1 : h ? 0 : lat + 2;
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b1;
        cpu_we_i = we;
        cpu_addr_i = addr;
        cpu_wdata_i = wdata;
        cpu_be_i = be;
        sb.push_back(e);
        cycles = 0;
        while (1) begin
            @(negedge clk_i);
            if (cpu_ready_o) break;
            cycles++;
            if (cycles > 100) begin
                checks++;
                errors++;
                $display("FAIL timeout@%h: no cpu_ready_o after %0d cycles", addr, cycles);
                finish_tb();
            end
        end
        last_rdata = cpu_rdata_o;
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        rec_q.delete();
    endtask

    initial begin
        int c, n0;
        mem_arr[32'h40 >> 2] = 32'hDEAD_BEEF;
        ref_mem[32'h40 >> 2] = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 32'(cpu_ready_o), 0);
        chk("rst_mem_req", 32'(mem_req_o), 0);
        chk("rst_mem_we", 32'(mem_we_o), 0);
        chk("rst_rdata", cpu_rdata_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_mem_be", 32'(mem_be_o), 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        lat = 3;
        do_req(0, 32'h40, 0, 0, 0, c);
        chk("t1_miss_cycles", c, 5);
        chk("t1_miss_rdata", last_rdata, 32'hDEAD_BEEF);
        do_req(0, 32'h40, 0, 0, 1, c);
        chk("t1_hit_cycles", c, 0);

        do_req(1, 32'h40, 32'h1122_3344, 4'b0011, 1, c);
        chk("t3_mem_be", 32'(last_be), 32'h3);
        do_req(0, 32'h40, 0, 0, 1, c);
        chk("t3_merged_rdata", last_rdata, 32'hDEAD_3344);

        lat = 0;
        n0 = nwr;
        do_req(1, 32'h80, 32'hCAFE_F00D, 4'hF, 0, c);
        chk("t4_mem_writes", nwr - n0, 1);
        do_req(0, 32'h80, 0, 0, 0, c);
        chk("t4_refill_rdata", last_rdata, 32'hCAFE_F00D);

        pulse_flush();
        foreach (sb[i]) chk("sb_drain", 1, 0);
        do_req(0, 32'h000, 0, 0, 0, c);
        do_req(0, 32'h040, 0, 0, 0, c);
        do_req(0, 32'h080, 0, 0, 0, c);
        do_req(0, 32'h0C0, 0, 0, 0, c);
        do_req(0, 32'h000, 0, 0, 1, c);
        do_req(0, 32'h100, 0, 0, 0, c);
        do_req(0, 32'h000, 0, 0, 1, c);
        do_req(0, 32'h040, 0, 0, 0, c);

        lat = 3;
        fork
            do_req(0, 32'h44, 0, 0, 0, c);
            begin
                repeat (2) @(posedge clk_i);
                #1 flush_i = 1'b1;
                @(posedge clk_i);
                #1 flush_i = 1'b0;
                rec_q.delete();
            end
        join
        chk("t5_cycles", c, 5);
        do_req(0, 32'h44, 0, 0, 0, c);
        do_req(0, 32'h000, 0, 0, 0, c);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            int k = $urandom_range(0, 99);
            a = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if (i % 40 == 0) lat = $urandom_range(0, 3);
            if (k < 4) pulse_flush();
            else if (k < 40) do_req(1, a, $urandom, 4'($urandom_range(0, 15)), -1, c);
            else do_req(0, a, 0, 0, -1, c);
        end

        lat = 3;
        do_req(0, 32'h40, 0, 0, -1, c);
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b1;
        cpu_we_i = 1'b1;
        cpu_addr_i = 32'h40;
        cpu_wdata_i = 32'h0BAD_0BAD;
        cpu_be_i = 4'hF;
        repeat (2) @(negedge clk_i);
        chk("t6_req_before_reset", 32'(mem_req_o), 1);
        #2 rst_ni = 1'b0;
        #1 chk("t6_req_async_drop", 32'(mem_req_o), 0);
        cpu_req_i = 1'b0;
        rec_q.delete();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        do_req(0, 32'h40, 0, 0, 0, c);
        do_req(0, 32'h000, 0, 0, 0, c);
        do_req(0, 32'h04C, 0, 0, 0, c);

        repeat (3) @(negedge clk_i);
        chk("sb_empty", sb.size(), 0);
        finish_tb();
    end

endmodule
